// File: rtl/avr_irq_ctrl.sv
// Interrupt controller for the AVR core: latches 8 peripheral lines as pending,
// applies a mask and fixed priority, and holds one request/vector until acked.
module avr_irq_ctrl #(
  parameter logic [15:0] BASE = 16'h0030,
  parameter int          SYNC = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  irq_src,
  input  logic        irq_ack,
  input  logic [15:0] address,
  input  logic [7:0]  data_i,
  input  logic        we,
  output logic [7:0]  data_o,
  output logic        hit,
  output logic        intr,
  output logic [2:0]  vect
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t      state_q;
  logic        intr_q;
  logic [2:0]  vect_q;
  logic [7:0]  imsk_q, iedg_q, ipnd_q, ipnd_d;
  logic [7:0]  s, s_q;
  logic [7:0]  set_v, clr_v, m;
  logic [2:0]  win;
  logic        sel_msk, sel_pnd, sel_edg, ack_take;

  generate
    if (SYNC == 0) begin : g_nosync
      assign s = irq_src;
    end else begin : g_sync
      logic [SYNC-1:0][7:0] sync_q;
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= irq_src;
          for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC-1];
    end
  endgenerate

  assign sel_msk = (address == BASE);
  assign sel_pnd = (address == BASE + 16'd1);
  assign sel_edg = (address == BASE + 16'd2);
  assign hit     = sel_msk | sel_pnd | sel_edg;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    data_o = 8'h00;
    if (sel_msk) data_o = imsk_q;
    if (sel_pnd) data_o = ipnd_q;
    if (sel_edg) data_o = iedg_q;
  end

  assign ack_take = (state_q == REQ) && irq_ack;
  assign set_v    = (iedg_q & s & ~s_q) | (~iedg_q & s);
  assign clr_v    = ((we && sel_pnd) ? data_i : 8'h00)
                  | (ack_take ? (8'h01 << vect_q) : 8'h00);
  // A new event on a bit outranks any clear of that bit in the same cycle.
  assign ipnd_d   = (ipnd_q & ~clr_v) | set_v;
  assign m        = ipnd_q & imsk_q;

  always_comb begin
    win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) win = 3'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      imsk_q <= 8'h00;
      iedg_q <= 8'hFF;
      ipnd_q <= 8'h00;
      s_q    <= 8'h00;
    end else begin
      ipnd_q <= ipnd_d;
      s_q    <= s;
      if (we && sel_msk) imsk_q <= data_i;
      if (we && sel_edg) iedg_q <= data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      intr_q  <= 1'b0;
      vect_q  <= 3'd0;
    end else begin
      case (state_q)
        IDLE: if (|m) begin
          state_q <= REQ;
          intr_q  <= 1'b1;
          vect_q  <= win;
        end
        REQ: if (irq_ack) begin
          state_q <= GAP;
          intr_q  <= 1'b0;
        end else if (!m[vect_q]) begin
          // Request withdrawn: its source was masked or cleared before the core took it.
          state_q <= IDLE;
          intr_q  <= 1'b0;
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign intr = intr_q;
  assign vect = vect_q;

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Bench for avr_irq_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the SYNC=0 instance.
module tb_avr_irq_ctrl;

  localparam logic [15:0] BASE = 16'h0030;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  irq_src = 8'h00;
  logic        irq_ack = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data_i = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  data_o, data_o2;
  logic        hit, hit2, intr, intr2;
  logic [2:0]  vect, vect2;

  int total = 0;
  int bad   = 0;

  // Behavioural model state (SYNC=0 instance).
  logic [7:0] m_msk, m_pnd, m_edg, m_prev;
  logic       m_intr, m_gap;
  int         m_vec;

  avr_irq_ctrl #(.BASE(BASE), .SYNC(0)) u_dut (
    .clock(clock), .reset_n(reset_n), .irq_src(irq_src), .irq_ack(irq_ack),
    .address(address), .data_i(data_i), .we(we),
    .data_o(data_o), .hit(hit), .intr(intr), .vect(vect)
  );

  avr_irq_ctrl #(.BASE(BASE), .SYNC(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .irq_src(irq_src), .irq_ack(irq_ack),
    .address(address), .data_i(data_i), .we(we),
    .data_o(data_o2), .hit(hit2), .intr(intr2), .vect(vect2)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    logic [7:0] pnd_n;
    int win;
    if (!reset_n) begin
      m_msk = 8'h00; m_pnd = 8'h00; m_edg = 8'hFF; m_prev = 8'h00;
      m_intr = 1'b0; m_gap = 1'b0; m_vec = 0;
      return;
    end
    pnd_n = m_pnd;
    if (we && address == BASE + 1) pnd_n = pnd_n & ~data_i;
    if (m_intr && irq_ack) pnd_n[m_vec] = 1'b0;
    for (int i = 0; i < 8; i++)
      if (irq_src[i] && (!m_edg[i] || !m_prev[i])) pnd_n[i] = 1'b1;
    win = -1;
    for (int i = 7; i >= 0; i--) if (m_pnd[i] && m_msk[i]) win = i;
    if (m_intr) begin
      if (irq_ack) begin m_intr = 1'b0; m_gap = 1'b1; end
      else if (!(m_pnd[m_vec] && m_msk[m_vec])) m_intr = 1'b0;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (win >= 0) begin
      m_intr = 1'b1; m_vec = win;
    end
    if (we && address == BASE)     m_msk = data_i;
    if (we && address == BASE + 2) m_edg = data_i;
    m_pnd  = pnd_n;
    m_prev = irq_src;
  endtask

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    if (a == BASE)     return m_msk;
    if (a == BASE + 1) return m_pnd;
    if (a == BASE + 2) return m_edg;
    return 8'h00;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address = a; data_i = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic h);
    address = a;
    #1;
    d = data_o; h = hit;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic h;
    reset_n = 1'b0; irq_src = 8'h00; we = 1'b0; irq_ack = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr got=%0d want=0", intr); end
    total++; if (vect !== 3'd0) begin bad++; $display("FAIL reset_vect got=%0d want=0", vect); end
    total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL reset_intr2 got=%0d want=0", intr2); end
    rd(BASE, d, h);
    total++; if (d !== 8'h00 || h !== 1'b1) begin bad++; $display("FAIL reset_imsk got=%h/%0d want=00/1", d, h); end
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h00 || h !== 1'b1) begin bad++; $display("FAIL reset_ipnd got=%h/%0d want=00/1", d, h); end
    rd(BASE + 16'd2, d, h);
    total++; if (d !== 8'hFF || h !== 1'b1) begin bad++; $display("FAIL reset_iedg got=%h/%0d want=FF/1", d, h); end
    tick();
    rd(BASE - 16'd1, d, h);
    total++; if (d !== 8'h00 || h !== 1'b0) begin bad++; $display("FAIL miss_below got=%h/%0d want=00/0", d, h); end
    rd(BASE + 16'd3, d, h);
    total++; if (d !== 8'h00 || h !== 1'b0) begin bad++; $display("FAIL miss_above got=%h/%0d want=00/0", d, h); end
  endtask

  task automatic test_single();
    logic [7:0] d; logic h;
    wr(BASE, 8'hFF);
    irq_src = 8'h20; tick(); irq_src = 8'h00;
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL single_early got=%0d want=0", intr); end
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h20) begin bad++; $display("FAIL single_ipnd got=%h want=20", d); end
    tick();
    total++; if (intr !== 1'b1 || vect !== 3'd5) begin bad++; $display("FAIL single_req got=%0d/%0d want=1/5", intr, vect); end
    total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL sync2_n2 got=%0d want=0", intr2); end
    tick();
    total++; if (intr2 !== 1'b0) begin bad++; $display("FAIL sync2_n3 got=%0d want=0", intr2); end
    tick();
    total++; if (intr2 !== 1'b1 || vect2 !== 3'd5) begin bad++; $display("FAIL sync2_req got=%0d/%0d want=1/5", intr2, vect2); end
    total++; if (intr !== 1'b1 || vect !== 3'd5) begin bad++; $display("FAIL single_hold got=%0d/%0d want=1/5", intr, vect); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    total++; if (intr !== 1'b0 || intr2 !== 1'b0) begin bad++; $display("FAIL single_ack got=%0d/%0d want=0/0", intr, intr2); end
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL single_ipnd_clr got=%h want=00", d); end
    tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL single_gap got=%0d want=0", intr); end
  endtask

  task automatic test_priority();
    irq_src = 8'h24; tick(); irq_src = 8'h00; tick();
    total++; if (intr !== 1'b1 || vect !== 3'd2) begin bad++; $display("FAIL prio_first got=%0d/%0d want=1/2", intr, vect); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL prio_gap got=%0d want=0", intr); end
    tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL prio_idle got=%0d want=0", intr); end
    tick();
    total++; if (intr !== 1'b1 || vect !== 3'd5) begin bad++; $display("FAIL prio_second got=%0d/%0d want=1/5", intr, vect); end
    irq_src = 8'h01; tick(); irq_src = 8'h00; tick();
    total++; if (intr !== 1'b1 || vect !== 3'd5) begin bad++; $display("FAIL prio_frozen got=%0d/%0d want=1/5", intr, vect); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick(); tick();
    total++; if (intr !== 1'b1 || vect !== 3'd0) begin bad++; $display("FAIL prio_third got=%0d/%0d want=1/0", intr, vect); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
  endtask

  task automatic test_mask();
    logic [7:0] d; logic h;
    wr(BASE, 8'h00);
    irq_src = 8'h08; tick(); irq_src = 8'h00; tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL mask_blocked got=%0d want=0", intr); end
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h08) begin bad++; $display("FAIL mask_ipnd got=%h want=08", d); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h08 || intr !== 1'b0) begin bad++; $display("FAIL stray_ack got=%h/%0d want=08/0", d, intr); end
    wr(BASE, 8'h08); tick();
    total++; if (intr !== 1'b1 || vect !== 3'd3) begin bad++; $display("FAIL mask_unmask got=%0d/%0d want=1/3", intr, vect); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
    wr(BASE, 8'hFF);
  endtask

  task automatic test_withdraw();
    logic [7:0] d; logic h;
    irq_src = 8'h02; tick(); irq_src = 8'h00; tick();
    total++; if (intr !== 1'b1 || vect !== 3'd1) begin bad++; $display("FAIL wd_req got=%0d/%0d want=1/1", intr, vect); end
    wr(BASE + 16'd1, 8'h02);
    tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL wd_drop got=%0d want=0", intr); end
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL wd_ipnd got=%h want=00", d); end
    irq_src = 8'h02; address = BASE + 16'd1; data_i = 8'h02; we = 1'b1;
    tick();
    we = 1'b0; irq_src = 8'h00;
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL set_beats_clr got=%h want=02", d); end
    tick();
    total++; if (intr !== 1'b1 || vect !== 3'd1) begin bad++; $display("FAIL wd_rereq got=%0d/%0d want=1/1", intr, vect); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
  endtask

  task automatic test_level();
    logic [7:0] d; logic h;
    wr(BASE + 16'd2, 8'h00);
    irq_src = 8'h01; tick(); tick();
    total++; if (intr !== 1'b1 || vect !== 3'd0) begin bad++; $display("FAIL lvl_req got=%0d/%0d want=1/0", intr, vect); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL lvl_ack got=%0d want=0", intr); end
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h01) begin bad++; $display("FAIL lvl_repend got=%h want=01", d); end
    tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL lvl_gap got=%0d want=0", intr); end
    tick();
    total++; if (intr !== 1'b1 || vect !== 3'd0) begin bad++; $display("FAIL lvl_rereq got=%0d/%0d want=1/0", intr, vect); end
    irq_src = 8'h00; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL lvl_clear got=%h want=00", d); end
    tick(); tick(); tick();
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL lvl_quiet got=%0d want=0", intr); end
    wr(BASE + 16'd2, 8'hFF);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic h;
    wr(BASE, 8'h7F);
    wr(BASE + 16'd2, 8'h0F);
    irq_src = 8'hC0; tick(); irq_src = 8'h00; tick();
    total++; if (intr !== 1'b1 || vect !== 3'd6) begin bad++; $display("FAIL rm_req got=%0d/%0d want=1/6", intr, vect); end
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    total++; if (intr !== 1'b0 || vect !== 3'd0) begin bad++; $display("FAIL rm_out got=%0d/%0d want=0/0", intr, vect); end
    rd(BASE, d, h);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rm_imsk got=%h want=00", d); end
    rd(BASE + 16'd1, d, h);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL rm_ipnd got=%h want=00", d); end
    rd(BASE + 16'd2, d, h);
    total++; if (d !== 8'hFF) begin bad++; $display("FAIL rm_iedg got=%h want=FF", d); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      irq_src = 8'($urandom & $urandom & $urandom);
      we      = ($urandom_range(0, 4) == 0);
      address = we ? BASE + 16'($urandom_range(0, 2)) : 16'(16'h002E + 16'($urandom_range(0, 6)));
      data_i  = 8'($urandom);
      irq_ack = m_intr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      #1;
      total++; if (intr !== m_intr) begin bad++; $display("FAIL rnd_intr c=%0d got=%0d want=%0d", c, intr, m_intr); end
      total++; if (vect !== 3'(m_vec)) begin bad++; $display("FAIL rnd_vect c=%0d got=%0d want=%0d", c, vect, m_vec); end
      total++; if (data_o !== model_rd(address)) begin bad++; $display("FAIL rnd_data c=%0d addr=%h got=%h want=%h", c, address, data_o, model_rd(address)); end
      total++; if (hit !== (address >= BASE && address <= BASE + 16'd2)) begin bad++; $display("FAIL rnd_hit c=%0d addr=%h got=%0d", c, address, hit); end
      tick();
    end
    reset_n = 1'b1; we = 1'b0; irq_ack = 1'b0; irq_src = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_withdraw();
    test_level();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
